// File: rtl/magnitude_pkg.sv
// Shared types, mode encodings and helpers for the vector magnitude unit.
package magnitude_pkg;

  // Widest operand the unit supports; helpers are written at this width.
  localparam int MAX_WIDTH = 16;

  localparam logic MODE_APPROX = 1'b0;
  localparam logic MODE_EXACT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SORT   = 3'd2,
    ST_SCALE  = 3'd3,
    ST_SUM    = 3'd4,
    ST_SQUARE = 3'd5,
    ST_ROOT   = 3'd6,
    ST_FINISH = 3'd7
  } state_t;

  // Magnitude of a sign-extended two's complement value as an unsigned
  // number. The most negative operand maps onto its positive power of two,
  // which still fits because the result is read back as unsigned.
  function automatic logic [MAX_WIDTH-1:0] abs_to_unsigned(input logic signed [MAX_WIDTH-1:0] v);
    logic [MAX_WIDTH-1:0] r;
    if (v[MAX_WIDTH-1]) begin
      r = (~unsigned'(v)) + MAX_WIDTH'(1);
    end else begin
      r = unsigned'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/magnitude_isqrt.sv
// Restoring bit-serial integer square root, one result bit per step, MSB
// first. The owning FSM loads the radicand and then issues WIDTH+1 steps;
// 'last' is high during the final step.
module magnitude_isqrt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [2*WIDTH:0] radicand,
  output logic [WIDTH:0]   root,
  output logic             last
);

  // Radicand padded to an even bit count so it splits into WIDTH+1 pairs.
  localparam int RADW = 2 * WIDTH + 2;
  // The remainder never exceeds twice the partial root.
  localparam int REMW = WIDTH + 2;
  localparam int TRW  = WIDTH + 4;
  localparam int CNTW = $clog2(WIDTH + 2);

  logic [RADW-1:0]  rad_r;
  logic [REMW-1:0]  rem_r;
  logic [WIDTH:0]   root_r;
  logic [CNTW-1:0]  cnt_r;

  logic [TRW-1:0]   rem_trial_s;
  logic [TRW-1:0]   trial_s;
  logic             fits_s;

  // Trial subtraction: bring down the next bit pair and test root*4+1.
  always_comb begin
    rem_trial_s = {rem_r, rad_r[RADW-1 -: 2]};
    trial_s     = {1'b0, root_r, 2'b01};
    fits_s      = (rem_trial_s >= trial_s);
  end

  // Iteration registers: load seeds a new root, step retires one bit.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      rad_r  <= '0;
      rem_r  <= '0;
      root_r <= '0;
      cnt_r  <= '0;
    end else if (load) begin
      rad_r  <= {1'b0, radicand};
      rem_r  <= '0;
      root_r <= '0;
      cnt_r  <= CNTW'(WIDTH + 1);
    end else if (step) begin
      rad_r <= rad_r << 2;
      cnt_r <= cnt_r - CNTW'(1);
      if (fits_s) begin
        rem_r  <= REMW'(rem_trial_s - trial_s);
        root_r <= {root_r[WIDTH-1:0], 1'b1};
      end else begin
        rem_r  <= REMW'(rem_trial_s);
        root_r <= {root_r[WIDTH-1:0], 1'b0};
      end
    end
  end

  assign root = root_r;
  assign last = (cnt_r == CNTW'(1));

endmodule

// File: rtl/vector_magnitude.sv
// Multi-cycle |(a, b)| unit with start/done handshake. Mode 0 uses the
// shift-add approximation max(x, x - x/8 + y/2); mode 1 returns the exact
// floor(sqrt(a*a + b*b)) through the serial root sub-block.
module vector_magnitude
  import magnitude_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   out,
  output logic             busy,
  output logic             done
);

  state_t state_r;
  state_t state_next_s;

  logic                     mode_r;
  logic signed [WIDTH-1:0]  in_a_r;
  logic signed [WIDTH-1:0]  in_b_r;
  logic [WIDTH-1:0]         a_r;
  logic [WIDTH-1:0]         b_r;
  logic [WIDTH-1:0]         x_r;
  logic [WIDTH-2:0]         y_half_r;
  logic [WIDTH-1:0]         t4_r;
  logic [WIDTH:0]           t5_r;

  logic [WIDTH:0]           out_r;
  logic                     busy_r;
  logic                     done_r;

  logic signed [MAX_WIDTH-1:0] a_ext_s;
  logic signed [MAX_WIDTH-1:0] b_ext_s;
  logic [WIDTH-1:0]         a_abs_s;
  logic [WIDTH-1:0]         b_abs_s;
  logic [WIDTH-1:0]         t4_s;
  logic [WIDTH:0]           t5_s;
  logic [WIDTH:0]           approx_s;
  logic [2*WIDTH:0]         a_wide_s;
  logic [2*WIDTH:0]         b_wide_s;
  logic [2*WIDTH:0]         sum_sq_s;

  logic                     root_load_s;
  logic                     root_step_s;
  logic [WIDTH:0]           root_s;
  logic                     root_last_s;

  magnitude_isqrt #(
    .WIDTH    (WIDTH)
  ) u_isqrt (
    .clk      (clk),
    .clear    (clear),
    .load     (root_load_s),
    .step     (root_step_s),
    .radicand (sum_sq_s),
    .root     (root_s),
    .last     (root_last_s)
  );

  // Datapath arithmetic for every stage, evaluated from the stage registers.
  always_comb begin
    a_ext_s  = MAX_WIDTH'(in_a_r);
    b_ext_s  = MAX_WIDTH'(in_b_r);
    a_abs_s  = WIDTH'(abs_to_unsigned(a_ext_s));
    b_abs_s  = WIDTH'(abs_to_unsigned(b_ext_s));
    t4_s     = x_r - {3'b000, x_r[WIDTH-1:3]};
    t5_s     = {1'b0, t4_r} + {2'b00, y_half_r};
    approx_s = ({1'b0, x_r} > t5_r) ? {1'b0, x_r} : t5_r;
    a_wide_s = {{(WIDTH+1){1'b0}}, a_r};
    b_wide_s = {{(WIDTH+1){1'b0}}, b_r};
    sum_sq_s = (a_wide_s * a_wide_s) + (b_wide_s * b_wide_s);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state and root sub-block control.
  always_comb begin
    state_next_s = state_r;
    root_load_s  = 1'b0;
    root_step_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (mode_r == MODE_EXACT) begin
          state_next_s = ST_SQUARE;
        end else begin
          state_next_s = ST_SORT;
        end
      end
      ST_SORT:   state_next_s = ST_SCALE;
      ST_SCALE:  state_next_s = ST_SUM;
      ST_SUM:    state_next_s = ST_FINISH;
      ST_SQUARE: begin
        root_load_s  = 1'b1;
        state_next_s = ST_ROOT;
      end
      ST_ROOT: begin
        root_step_s = 1'b1;
        if (root_last_s) begin
          state_next_s = ST_FINISH;
        end else begin
          state_next_s = ST_ROOT;
        end
      end
      ST_FINISH: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Operand capture and approximation pipeline, one stage per state.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      mode_r   <= MODE_APPROX;
      in_a_r   <= '0;
      in_b_r   <= '0;
      a_r      <= '0;
      b_r      <= '0;
      x_r      <= '0;
      y_half_r <= '0;
      t4_r     <= '0;
      t5_r     <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            mode_r <= mode;
            in_a_r <= in_a;
            in_b_r <= in_b;
          end
        end
        ST_LOAD: begin
          a_r <= a_abs_s;
          b_r <= b_abs_s;
        end
        ST_SORT: begin
          if (a_r >= b_r) begin
            x_r      <= a_r;
            y_half_r <= b_r[WIDTH-1:1];
          end else begin
            x_r      <= b_r;
            y_half_r <= a_r[WIDTH-1:1];
          end
        end
        ST_SCALE: t4_r <= t4_s;
        ST_SUM:   t5_r <= t5_s;
        default: ;
      endcase
    end
  end

  // Handshake outputs: result and done are written together in FINISH.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      out_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state_r == ST_FINISH) begin
        out_r  <= (mode_r == MODE_EXACT) ? root_s : approx_s;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else if ((state_r == ST_IDLE) && start) begin
        busy_r <= 1'b1;
      end
    end
  end

  assign out  = out_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_vector_magnitude.sv
// Bench for vector_magnitude at WIDTH 4, 8 and 16 with a result scoreboard.
module tb_vector_magnitude;

  logic        clk_s = 1'b0;
  logic        clear_s;

  logic        start4_s, mode4_s, busy4_s, done4_s;
  logic [3:0]  a4_s, b4_s;
  logic [4:0]  out4_s;
  logic        start8_s, mode8_s, busy8_s, done8_s;
  logic [7:0]  a8_s, b8_s;
  logic [8:0]  out8_s;
  logic        start16_s, mode16_s, busy16_s, done16_s;
  logic [15:0] a16_s, b16_s;
  logic [16:0] out16_s;

  typedef struct {
    int inst;
    int value;
    int lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk_s = ~clk_s;

  vector_magnitude #(.WIDTH(4)) u_dut4 (
    .clk(clk_s), .clear(clear_s), .start(start4_s), .mode(mode4_s),
    .in_a(a4_s), .in_b(b4_s), .out(out4_s), .busy(busy4_s), .done(done4_s)
  );
  vector_magnitude #(.WIDTH(8)) u_dut8 (
    .clk(clk_s), .clear(clear_s), .start(start8_s), .mode(mode8_s),
    .in_a(a8_s), .in_b(b8_s), .out(out8_s), .busy(busy8_s), .done(done8_s)
  );
  vector_magnitude #(.WIDTH(16)) u_dut16 (
    .clk(clk_s), .clear(clear_s), .start(start16_s), .mode(mode16_s),
    .in_a(a16_s), .in_b(b16_s), .out(out16_s), .busy(busy16_s), .done(done16_s)
  );

  function automatic int width_of(input int inst);
    case (inst)
      0:       return 4;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] get_out(input int inst);
    case (inst)
      0:       return {27'd0, out4_s};
      1:       return {23'd0, out8_s};
      default: return {15'd0, out16_s};
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0:       return busy4_s;
      1:       return busy8_s;
      default: return busy16_s;
    endcase
  endfunction

  function automatic logic get_done(input int inst);
    case (inst)
      0:       return done4_s;
      1:       return done8_s;
      default: return done16_s;
    endcase
  endfunction

  // Reference: approximation from its defining formula, exact root by search.
  function automatic int ref_mag(input bit m, input int a, input int b);
    int     ua, ub, x, y, t4, t5;
    longint s, lo, hi, mid;
    ua = (a < 0) ? -a : a;
    ub = (b < 0) ? -b : b;
    if (!m) begin
      x  = (ua > ub) ? ua : ub;
      y  = (ua > ub) ? ub : ua;
      t4 = x - (x / 8);
      t5 = t4 + (y / 2);
      return (t5 > x) ? t5 : x;
    end
    s  = longint'(ua) * ua + longint'(ub) * ub;
    lo = 0;
    hi = 64'd131072;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= s) lo = mid;
      else                hi = mid - 1;
    end
    return int'(lo);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int inst, input logic st, input logic m, input int a, input int b);
    case (inst)
      0: begin start4_s = st;  mode4_s = m;  a4_s = a[3:0];   b4_s = b[3:0];   end
      1: begin start8_s = st;  mode8_s = m;  a8_s = a[7:0];   b8_s = b[7:0];   end
      default: begin start16_s = st; mode16_s = m; a16_s = a[15:0]; b16_s = b[15:0]; end
    endcase
  endtask

  // Called at a negedge: pulses start for one edge and scrambles operands after.
  task automatic issue(input int inst, input bit m, input int a, input int b);
    exp_t e;
    e.inst  = inst;
    e.value = ref_mag(m, a, b);
    e.lat   = m ? (width_of(inst) + 4) : 5;
    sb_q.push_back(e);
    drive(inst, 1'b1, m, a, b);
    @(negedge clk_s);
    drive(inst, 1'b0, ~m, int'($urandom), int'($urandom));
    check($sformatf("busy_after_start w%0d", width_of(inst)), {31'd0, get_busy(inst)}, 32'd1);
  endtask

  // Waits (bounded) for done; base is the number of edges already past E0.
  task automatic wait_done(input int inst, input int base);
    int   k;
    bit   seen;
    exp_t e;
    k    = base;
    seen = 1'b0;
    while (!seen && k < 200) begin
      @(negedge clk_s);
      k++;
      if (get_done(inst)) seen = 1'b1;
    end
    check($sformatf("done_seen w%0d", width_of(inst)), {31'd0, seen}, 32'd1);
    check($sformatf("scoreboard_nonempty w%0d", width_of(inst)), {31'd0, (sb_q.size() > 0)}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (seen) begin
        check($sformatf("result w%0d", width_of(inst)), get_out(inst), e.value);
        check($sformatf("latency w%0d", width_of(inst)), k, e.lat);
        check($sformatf("busy_at_done w%0d", width_of(inst)), {31'd0, get_busy(inst)}, 32'd0);
      end
    end
  endtask

  task automatic run_op(input int inst, input bit m, input int a, input int b);
    issue(inst, m, a, b);
    wait_done(inst, 0);
  endtask

  function automatic int rnd_signed(input int w);
    return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
  endfunction

  initial begin
    int lim, w, ra, rb, done_cnt;

    clear_s = 1'b1;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 0, 0);
    @(negedge clk_s);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_out w%0d", width_of(i)), get_out(i), 32'd0);
      check($sformatf("reset_busy w%0d", width_of(i)), {31'd0, get_busy(i)}, 32'd0);
      check($sformatf("reset_done w%0d", width_of(i)), {31'd0, get_done(i)}, 32'd0);
    end
    @(negedge clk_s);
    clear_s = 1'b0;
    @(negedge clk_s);

    // Directed WIDTH=8 cases.
    run_op(1, 1'b0, 3, 4);
    run_op(1, 1'b1, 100, -100);
    run_op(1, 1'b0, 100, -100);
    run_op(1, 1'b1, -128, -128);
    run_op(1, 1'b0, -128, -128);

    // Start while busy is ignored; start in the done cycle is accepted.
    issue(1, 1'b0, 3, 4);
    drive(1, 1'b1, 1'b1, 100, 100);
    @(negedge clk_s);
    drive(1, 1'b0, 1'b0, 0, 0);
    wait_done(1, 1);
    issue(1, 1'b0, 100, 100);
    wait_done(1, 0);

    // Clear in the middle of the root iteration.
    issue(1, 1'b1, 100, 100);
    repeat (5) @(negedge clk_s);
    check("out_holds_during_op", get_out(1), 32'd138);
    #2;
    clear_s = 1'b1;
    #1;
    check("clear_out", get_out(1), 32'd0);
    check("clear_busy", {31'd0, get_busy(1)}, 32'd0);
    check("clear_done", {31'd0, get_done(1)}, 32'd0);
    @(negedge clk_s);
    clear_s = 1'b0;
    sb_q.delete();
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk_s);
      if (get_done(1)) done_cnt++;
    end
    check("no_done_after_clear", done_cnt, 32'd0);
    run_op(1, 1'b1, 0, 0);
    run_op(1, 1'b0, 0, 0);

    // Sweep every width and both modes, corners first.
    for (int inst = 0; inst < 3; inst++) begin
      w   = width_of(inst);
      lim = 1 << (w - 1);
      for (int m = 0; m < 2; m++) begin
        run_op(inst, m[0], 0, 0);
        run_op(inst, m[0], -lim, rnd_signed(w));
        run_op(inst, m[0], rnd_signed(w), -lim);
        run_op(inst, m[0], -lim, -lim);
        run_op(inst, m[0], lim - 1, -lim);
        for (int n = 0; n < 6; n++) begin
          ra = rnd_signed(w);
          rb = rnd_signed(w);
          run_op(inst, m[0], ra, rb);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
